ysyx_22040386_mdu_seq: RTL and testbench

//  Multi-cycle sequencer for RV64M multiply/divide, sitting beside the EX-stage ALU.

---
 rtl/ysyx_22040386_mdu_seq.sv | 181 ++++++++++++++++++
 tb/tb_ysyx_22040386_mdu_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040386_mdu_seq.sv
// Multi-cycle RV64M multiply/divide sequencer: shift-add multiply, restoring divide.
// One op in flight, stalls the front end while busy, squashed by pipeline flush.
module ysyx_22040386_mdu_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [2:0]      i_funct3,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic            o_stall
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Handshake: a request is i_valid held stable while o_stall=1; the result is
  // taken in the single cycle o_valid=1, after which the sequencer is idle again.
  state_e            r_state;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_result;
  logic [2:0]        r_funct3;
  logic              r_word;
  logic              r_neg;
  logic              r_rem_neg;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dvsr;

  logic              w_is_div;
  logic              w_sgn1;
  logic              w_sgn2;
  logic [XLEN-1:0]   w_ext1;
  logic [XLEN-1:0]   w_ext2;
  logic              w_neg1;
  logic              w_neg2;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic [XLEN-1:0]   w_min;
  logic              w_div_zero;
  logic              w_ovf;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN-1:0]   w_quo_init;

  logic [2*XLEN-1:0] w_acc_n;
  logic [XLEN:0]     w_trial;
  logic [XLEN:0]     w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_n;
  logic [XLEN-1:0]   w_quo_n;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_mul_res;
  logic [XLEN-1:0]   w_div_res;
  logic [XLEN-1:0]   w_final;

  function automatic logic [XLEN-1:0] fix_word(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Operand decode: MULHSU treats only rs1 as signed; MUL's low half is sign-agnostic.
  always_comb begin
    w_is_div      = i_funct3[2];
    w_sgn1        = ~((i_funct3 == 3'b011) || (i_funct3 == 3'b101) || (i_funct3 == 3'b111));
    w_sgn2        = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) ||
                    (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    w_ext1        = i_word ? {{(XLEN-32){w_sgn1 & i_src1[31]}}, i_src1[31:0]} : i_src1;
    w_ext2        = i_word ? {{(XLEN-32){w_sgn2 & i_src2[31]}}, i_src2[31:0]} : i_src2;
    w_neg1        = w_sgn1 & w_ext1[XLEN-1];
    w_neg2        = w_sgn2 & w_ext2[XLEN-1];
    w_mag1        = w_neg1 ? (~w_ext1 + 1'b1) : w_ext1;
    w_mag2        = w_neg2 ? (~w_ext2 + 1'b1) : w_ext2;
    w_min         = i_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    w_div_zero    = w_is_div & (w_ext2 == '0);
    w_ovf         = w_is_div & ~i_funct3[0] & (w_ext1 == w_min) & (&w_ext2);
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = i_funct3[1] ? w_ext1 : '1;
    end else if (w_ovf) begin
      w_special_res = i_funct3[1] ? '0 : w_min;
    end
    // Word divides start with the dividend in the upper half so 32 shifts consume it.
    w_quo_init    = i_word ? (w_mag1 << 32) : w_mag1;
  end

  // One iteration of each datapath plus the sign fix applied on the final edge.
  always_comb begin
    w_acc_n    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_trial    = {r_rem, r_quo[XLEN-1]};
    w_diff     = w_trial - {1'b0, r_dvsr};
    w_ge       = ~w_diff[XLEN];
    w_rem_n    = w_ge ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
    w_quo_n    = {r_quo[XLEN-2:0], w_ge};
    w_prod_fix = r_neg ? (~w_acc_n + 1'b1) : w_acc_n;
    w_mul_res  = (r_funct3[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
    if (r_funct3[1]) begin
      w_div_res = r_rem_neg ? (~w_rem_n + 1'b1) : w_rem_n;
    end else begin
      w_div_res = r_neg ? (~w_quo_n + 1'b1) : w_quo_n;
    end
    w_final    = fix_word(r_word, r_funct3[2] ? w_div_res : w_mul_res);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_result  <= '0;
      r_funct3  <= '0;
      r_word    <= 1'b0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvsr    <= '0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_funct3  <= i_funct3;
            r_word    <= i_word;
            r_neg     <= w_neg1 ^ w_neg2;
            r_rem_neg <= w_neg1;
            r_acc     <= '0;
            r_mcand   <= {{XLEN{1'b0}}, w_mag1};
            r_mplier  <= w_mag2;
            r_rem     <= '0;
            r_quo     <= w_quo_init;
            r_dvsr    <= w_mag2;
            if (w_div_zero || w_ovf) begin
              r_state  <= S_DONE;
              r_result <= fix_word(i_word, w_special_res);
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= i_word ? CW'(32) : CW'(XLEN);
            end
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_n;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_rem    <= w_rem_n;
          r_quo    <= w_quo_n;
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state  <= S_DONE;
            r_result <= w_final;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready  = (r_state == S_IDLE);
  assign o_valid  = (r_state == S_DONE) & ~i_flush;
  assign o_result = r_result;
  assign o_stall  = i_valid & ~o_valid & ~i_flush;

endmodule

// File: tb/tb_ysyx_22040386_mdu_seq.sv
// Bench for the M-extension sequencer: directed corner ops, random ops against a
// reference model, flush and mid-op reset behaviour.
module tb_ysyx_22040386_mdu_seq;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [2:0]  i_funct3;
  logic        i_word;
  logic [63:0] i_src1;
  logic [63:0] i_src2;
  logic        i_flush;
  logic        o_ready;
  logic        o_valid;
  logic [63:0] o_result;
  logic        o_stall;

  int          n_checks;
  int          n_fail;
  logic [63:0] exp_q[$];
  string       tag_q[$];
  logic [63:0] last_res;

  ysyx_22040386_mdu_seq #(.XLEN(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .i_funct3 (i_funct3),
    .i_word   (i_word),
    .i_src1   (i_src1),
    .i_src2   (i_src2),
    .i_flush  (i_flush),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_stall  (o_stall)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mdu(input logic [2:0] f3, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       p;
    logic signed [63:0] sa, sb;
    logic signed [31:0] ha, hb;
    logic [31:0]        ua, ub, t;
    logic [63:0]        r;
    r = '0;
    p = '0;
    t = '0;
    sa = $signed(a);
    sb = $signed(b);
    ua = a[31:0];
    ub = b[31:0];
    ha = $signed(ua);
    hb = $signed(ub);
    if (w) begin
      case (f3)
        3'b100: begin
          if (ub == 32'd0) t = 32'hFFFFFFFF;
          else if (ua == 32'h80000000 && ub == 32'hFFFFFFFF) t = 32'h80000000;
          else t = ha / hb;
        end
        3'b101: begin
          if (ub == 32'd0) t = 32'hFFFFFFFF;
          else t = ua / ub;
        end
        3'b110: begin
          if (ub == 32'd0) t = ua;
          else if (ua == 32'h80000000 && ub == 32'hFFFFFFFF) t = 32'd0;
          else t = ha % hb;
        end
        3'b111: begin
          if (ub == 32'd0) t = ua;
          else t = ua % ub;
        end
        default: t = ua * ub;
      endcase
      r = {{32{t[31]}}, t};
    end else begin
      case (f3)
        3'b000: r = a * b;
        3'b001: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
        3'b010: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = p[127:64]; end
        3'b011: begin p = {64'd0, a} * {64'd0, b};             r = p[127:64]; end
        3'b100: begin
          if (b == 64'd0) r = '1;
          else if (a == 64'h8000000000000000 && b == '1) r = a;
          else r = sa / sb;
        end
        3'b101: begin
          if (b == 64'd0) r = '1;
          else r = a / b;
        end
        3'b110: begin
          if (b == 64'd0) r = a;
          else if (a == 64'h8000000000000000 && b == '1) r = 64'd0;
          else r = sa % sb;
        end
        default: begin
          if (b == 64'd0) r = a;
          else r = a % b;
        end
      endcase
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic [63:0] be;
    logic        sp;
    be = w ? {32'd0, b[31:0]} : b;
    sp = 1'b0;
    if (f3[2]) begin
      if (be == 64'd0) sp = 1'b1;
      else if (!f3[0] && w && a[31:0] == 32'h80000000 && b[31:0] == 32'hFFFFFFFF) sp = 1'b1;
      else if (!f3[0] && !w && a == 64'h8000000000000000 && b == '1) sp = 1'b1;
    end
    if (sp) return 1;
    return w ? 33 : 65;
  endfunction

  // driver: called just after a rising edge (cycle 0 = accept cycle)
  task automatic do_op(input string tag, input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat);
    int cyc;
    int stall_bad;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    i_valid  = 1'b1;
    i_funct3 = f3;
    i_word   = w;
    i_src1   = a;
    i_src2   = b;
    cyc = 0;
    stall_bad = 0;
    while (cyc < 200) begin
      @(negedge clk);
      if (o_valid) break;
      if (o_stall !== 1'b1) stall_bad++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, "_latency"}, 64'(cyc), 64'(lat));
    check_eq({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
    if (cyc >= 200) begin
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(tag_q.pop_front());
      end
    end else begin
      check_eq({tag, "_stall_done"}, 64'(o_stall), 64'd0);
      last_res = exp;
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_ready_after"}, 64'(o_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_rand_op(input string tag, input logic [2:0] f3, input logic w,
                            input logic [63:0] a, input logic [63:0] b);
    do_op(tag, f3, w, a, b, ref_mdu(f3, w, a, b), ref_lat(f3, w, a, b));
  endtask

  // scoreboard: compare every result pulse against the oldest expectation
  always @(negedge clk) begin
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 64'(o_valid), 64'd0);
      end else begin
        check_eq({tag_q.pop_front(), "_result"}, o_result, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a, b;
    logic [2:0]  word_ops [5];
    n_checks = 0;
    n_fail   = 0;
    last_res = '0;
    word_ops[0] = 3'b000; word_ops[1] = 3'b100; word_ops[2] = 3'b101;
    word_ops[3] = 3'b110; word_ops[4] = 3'b111;
    rst_n = 1'b0; i_valid = 1'b0; i_funct3 = '0; i_word = 1'b0;
    i_src1 = '0; i_src2 = '0; i_flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready",  64'(o_ready), 64'd1);
    check_eq("rst_valid",  64'(o_valid), 64'd0);
    check_eq("rst_result", o_result,     64'd0);
    check_eq("rst_stall",  64'(o_stall), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed corner ops
    do_op("mul",     3'b000, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 65);
    do_op("mulhu",   3'b011, 1'b0, '1, '1, 64'hFFFFFFFFFFFFFFFE, 65);
    do_op("mulhsu",  3'b010, 1'b0, '1, 64'd2, 64'hFFFFFFFFFFFFFFFF, 65);
    do_op("mulh",    3'b001, 1'b0, '1, '1, 64'd0, 65);
    do_op("div",     3'b100, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 65);
    do_op("rem",     3'b110, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 65);
    do_op("divu0",   3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1);
    do_op("remu0",   3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    do_op("div_ovf", 3'b100, 1'b0, 64'h8000000000000000, '1, 64'h8000000000000000, 1);
    do_op("divw_ovf",3'b100, 1'b1, 64'h80000000, '1, 64'hFFFFFFFF80000000, 1);
    do_op("remw_ovf",3'b110, 1'b1, 64'h80000000, '1, 64'd0, 1);
    do_op("divuw",   3'b101, 1'b1, 64'hFFFFFFFF, 64'd1, 64'hFFFFFFFFFFFFFFFF, 33);
    do_op("remuw",   3'b111, 1'b1, 64'hFFFFFFFF, 64'h10, 64'd15, 33);
    do_op("mulw",    3'b000, 1'b1, 64'h7FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, 33);

    // random ops against the reference model
    for (int k = 0; k < 12; k++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = w ? word_ops[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = 64'd0;
        1:       b = 64'($urandom_range(1, 9));
        default: b = {$urandom, $urandom};
      endcase
      do_rand_op("rand", f3, w, a, b);
    end

    // flush at cycle 10 of a MUL, then a DIV accepted in cycle 11
    i_valid = 1'b1; i_funct3 = 3'b000; i_word = 1'b0; i_src1 = 64'd5; i_src2 = 64'd6;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    i_flush = 1'b1;
    @(negedge clk);
    check_eq("flush_valid", 64'(o_valid), 64'd0);
    check_eq("flush_stall", 64'(o_stall), 64'd0);
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    check_eq("flush_ready",  64'(o_ready), 64'd1);
    check_eq("flush_result", o_result, last_res);
    do_op("div_after_flush", 3'b100, 1'b0, 64'd100, 64'hFFFFFFFFFFFFFFF9, 64'hFFFFFFFFFFFFFFF2, 65);

    // reset pulse at cycle 20 of a MUL
    i_valid = 1'b1; i_funct3 = 3'b000; i_word = 1'b0; i_src1 = 64'd9; i_src2 = 64'd9;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    i_valid = 1'b0;
    #2;
    check_eq("midrst_ready",  64'(o_ready), 64'd1);
    check_eq("midrst_valid",  64'(o_valid), 64'd0);
    check_eq("midrst_result", o_result,     64'd0);
    check_eq("midrst_stall",  64'(o_stall), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op("mul_after_rst", 3'b000, 1'b0, 64'd9, 64'd9, 64'd81, 65);

    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
